// File: rtl/galaxian_dl_pkg.sv
// Shared types and memory-map constants for the Galaxian download loader.
// The region decoder lives here so the map is defined in one place.
package galaxian_dl_pkg;

  typedef enum logic [1:0] {
    NOROM,
    LOAD,
    HOLD,
    RUN
  } dl_state_t;

  typedef enum logic [2:0] {
    RGN_NONE,
    RGN_PGM,
    RGN_GFX1K,
    RGN_GFX1H,
    RGN_PROM
  } region_t;

  localparam logic [15:0] PGM_BASE   = 16'h0000;
  localparam logic [15:0] GFX1K_BASE = 16'h4000;
  localparam logic [15:0] GFX1H_BASE = 16'h5000;
  localparam logic [15:0] PROM_BASE  = 16'h6000;
  localparam logic [15:0] IMG_SIZE   = 16'h6020;

  function automatic logic in_span(input logic [15:0] a,
                                   input logic [15:0] base,
                                   input logic [15:0] limit);
    return (a >= base) && (a < limit);
  endfunction

  // Each region ends where the next one begins; IMG_SIZE closes the PROM.
  function automatic region_t decode_region(input logic [24:0] addr);
    region_t r;
    r = RGN_NONE;
    if (addr[24:16] == 9'd0) begin
      if (in_span(addr[15:0], PGM_BASE, GFX1K_BASE))
        r = RGN_PGM;
      else if (in_span(addr[15:0], GFX1K_BASE, GFX1H_BASE))
        r = RGN_GFX1K;
      else if (in_span(addr[15:0], GFX1H_BASE, PROM_BASE))
        r = RGN_GFX1H;
      else if (in_span(addr[15:0], PROM_BASE, IMG_SIZE))
        r = RGN_PROM;
    end
    return r;
  endfunction

endpackage

// File: rtl/galaxian_dl_loader_if.sv
// ioctl download bus from data_io: data_io drives it (master), the loader
// consumes it (slave).
interface galaxian_dl_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout
  );

  modport slave (
    input ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout
  );
endinterface

// File: rtl/dl_rst_stretch.sv
// Loadable down-counter that stops at zero; done is high while the count is zero.
// Loading N gives N further cycles before done rises.
module dl_rst_stretch (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic        done
);

  logic [15:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= 16'd0;
    else if (load)
      count <= load_value;
    else if (count != 16'd0)
      count <= count - 16'd1;
  end

  assign done = (count == 16'd0);

endmodule

// File: rtl/galaxian_dl_loader.sv
// Routes the data_io download stream into the four Galaxian ROM regions and
// keeps the core in reset until a complete, clean image has been loaded.
module galaxian_dl_loader
  import galaxian_dl_pkg::*;
#(
  parameter logic [7:0]  DL_INDEX = 8'd0,
  parameter int unsigned RST_HOLD = 255
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  galaxian_dl_loader_if.slave        ioctl,
  input  logic                       user_reset,
  output logic                       core_reset,
  output logic [15:0]                dl_addr,
  output logic [7:0]                 dl_data,
  output logic                       pgm_we,
  output logic                       gfx1k_we,
  output logic                       gfx1h_we,
  output logic                       prom_we,
  output logic                       dl_busy,
  output logic                       rom_ok,
  output logic                       oob_err
);

  localparam logic [15:0] HOLD_LOAD = 16'(RST_HOLD - 1);

  dl_state_t   state;
  region_t     region;
  logic        dl_prev;
  logic [15:0] byte_cnt;
  logic        index_ok;
  logic        accept;
  logic        in_map;
  logic        dl_rise;
  logic        dl_fall;
  logic        enter_load;
  logic        image_good;
  logic        hold_load;
  logic        hold_done;

  assign index_ok   = (ioctl.ioctl_index == DL_INDEX);
  assign accept     = ioctl.ioctl_download & ioctl.ioctl_wr & index_ok;
  assign region     = decode_region(ioctl.ioctl_addr);
  assign in_map     = (region != RGN_NONE);
  assign dl_rise    = ioctl.ioctl_download & ~dl_prev & index_ok;
  assign dl_fall    = ~ioctl.ioctl_download & dl_prev;
  assign enter_load = dl_rise & (state != LOAD);
  assign image_good = (byte_cnt == IMG_SIZE) & ~oob_err;
  assign hold_load  = (state == LOAD) & dl_fall & image_good;

  // Write path: one registered strobe per accepted in-map byte.
  // NOTE: every clocked register uses <= so all of them sample the same
  // pre-edge values; a blocking = here would chain updates within one edge.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_prev  <= 1'b0;
      dl_addr  <= 16'd0;
      dl_data  <= 8'd0;
      pgm_we   <= 1'b0;
      gfx1k_we <= 1'b0;
      gfx1h_we <= 1'b0;
      prom_we  <= 1'b0;
    end else begin
      dl_prev  <= ioctl.ioctl_download;
      pgm_we   <= accept & (region == RGN_PGM);
      gfx1k_we <= accept & (region == RGN_GFX1K);
      gfx1h_we <= accept & (region == RGN_GFX1H);
      prom_we  <= accept & (region == RGN_PROM);
      if (accept) begin
        dl_addr <= ioctl.ioctl_addr[15:0];
        dl_data <= ioctl.ioctl_dout;
      end
    end
  end

  dl_rst_stretch u_hold (
    .clk        (clk_sys),
    .rst        (reset),
    .load       (hold_load),
    .load_value (HOLD_LOAD),
    .done       (hold_done)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= NOROM;
      core_reset <= 1'b1;
      dl_busy    <= 1'b0;
      rom_ok     <= 1'b0;
      oob_err    <= 1'b0;
      byte_cnt   <= 16'd0;
    end else if (enter_load) begin
      // A byte arriving on the rising-edge cycle is folded into the fresh tally.
      state      <= LOAD;
      core_reset <= 1'b1;
      dl_busy    <= 1'b1;
      rom_ok     <= 1'b0;
      oob_err    <= accept & ~in_map;
      byte_cnt   <= {15'd0, accept & in_map};
    end else begin
      if (accept & in_map & (byte_cnt != 16'hFFFF))
        byte_cnt <= byte_cnt + 16'd1;
      if (accept & ~in_map)
        oob_err <= 1'b1;

      case (state)
        NOROM: ;
        LOAD: begin
          if (dl_fall) begin
            rom_ok  <= image_good;
            dl_busy <= 1'b0;
            state   <= image_good ? HOLD : NOROM;
          end
        end
        HOLD: begin
          if (hold_done) begin
            state      <= RUN;
            core_reset <= user_reset;
          end
        end
        RUN:     core_reset <= user_reset;
        default: state <= NOROM;
      endcase
    end
  end

endmodule

// File: tb/tb_galaxian_dl_loader.sv
// Scoreboard bench: stimulus pushes expected writes, a negedge monitor pops
// and compares them; status outputs are checked against a map-level model.
module tb_galaxian_dl_loader;

  localparam int HOLD_CYC = 4;
  localparam int IMG      = 'h6020;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        user_reset = 1'b0;
  logic        core_reset;
  logic [15:0] dl_addr;
  logic [7:0]  dl_data;
  logic        pgm_we, gfx1k_we, gfx1h_we, prom_we;
  logic        dl_busy, rom_ok, oob_err;

  galaxian_dl_loader_if ioctl ();

  always #5 clk = ~clk;

  galaxian_dl_loader #(
    .DL_INDEX (8'd0),
    .RST_HOLD (HOLD_CYC)
  ) dut (
    .clk_sys    (clk),
    .reset      (rst),
    .ioctl      (ioctl),
    .user_reset (user_reset),
    .core_reset (core_reset),
    .dl_addr    (dl_addr),
    .dl_data    (dl_data),
    .pgm_we     (pgm_we),
    .gfx1k_we   (gfx1k_we),
    .gfx1h_we   (gfx1h_we),
    .prom_we    (prom_we),
    .dl_busy    (dl_busy),
    .rom_ok     (rom_ok),
    .oob_err    (oob_err)
  );

  typedef struct {
    logic [3:0]  we;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  model_cnt = 0;
  bit  model_oob = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory map as a plain address ladder; result is {prom,gfx1h,gfx1k,pgm}.
  function automatic logic [3:0] model_we(input logic [24:0] a);
    if (a >= 25'h6020) return 4'b0000;
    if (a >= 25'h6000) return 4'b1000;
    if (a >= 25'h5000) return 4'b0100;
    if (a >= 25'h4000) return 4'b0010;
    return 4'b0001;
  endfunction

  // Called right at a negedge: drives one byte and records what it should do.
  task automatic drive_byte(input logic [24:0] a, input logic [7:0] d, input logic [7:0] idx);
    logic [3:0] we;
    ioctl.ioctl_wr    = 1'b1;
    ioctl.ioctl_addr  = a;
    ioctl.ioctl_dout  = d;
    ioctl.ioctl_index = idx;
    if (ioctl.ioctl_download && idx == 8'd0) begin
      we = model_we(a);
      if (we == 4'b0000) model_oob = 1'b1;
      else begin
        if (model_cnt < 65535) model_cnt++;
        exp_q.push_back('{we, a[15:0], d});
      end
    end
  endtask

  // mode 0: sequential, 1: random in map, 2: random with stray high address bits
  task automatic send_image(input int n, input int mode, input int stray_at, input int gap_pct);
    int i;
    int sent;
    logic [24:0] a;
    i = 0;
    sent = 0;
    model_cnt = 0;
    model_oob = 1'b0;
    @(negedge clk);
    ioctl.ioctl_download = 1'b1;
    ioctl.ioctl_index    = 8'd0;
    while (sent < n) begin
      if (i > 0) @(negedge clk);
      if (i == 1) begin
        check("load_busy", dl_busy, 1);
        check("load_rom_ok_clear", rom_ok, 0);
        check("load_oob_entry", oob_err, model_oob);
        check("load_core_reset", core_reset, 1);
      end
      if (i == stray_at)
        drive_byte(25'h6020, 8'($urandom), 8'd0);
      else if (i > 0 && int'($urandom_range(99)) < gap_pct)
        ioctl.ioctl_wr = 1'b0;
      else begin
        if (mode == 0) a = 25'(sent);
        else a = 25'($urandom_range(0, 'h601F));
        if (mode == 2 && $urandom_range(7) == 0) a[16 + $urandom_range(8)] = 1'b1;
        drive_byte(a, 8'($urandom), 8'd0);
        sent++;
      end
      i++;
    end
    @(negedge clk);
    ioctl.ioctl_wr       = 1'b0;
    ioctl.ioctl_download = 1'b0;
  endtask

  // Starts at the negedge where download was dropped.
  task automatic after_fall(input bit interrupt);
    bit good;
    bit stuck;
    int k;
    good = (model_cnt == IMG) && !model_oob;
    @(negedge clk);
    check("rom_ok", rom_ok, good);
    check("oob_err", oob_err, model_oob);
    check("busy_after_fall", dl_busy, 0);
    check("reset_after_fall", core_reset, 1);
    if (interrupt) begin
      repeat (2) @(negedge clk);
      check("hold_reset", core_reset, 1);
    end else if (good) begin
      k = 1;
      while (core_reset && k < 20) begin
        @(negedge clk);
        k++;
      end
      check("release_delay", k, HOLD_CYC + 1);
    end else begin
      stuck = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (!core_reset || dl_busy) stuck = 1'b1;
      end
      check("norom_stays", stuck, 0);
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_values();
    check("rst_core_reset", core_reset, 1);
    check("rst_we", {prom_we, gfx1h_we, gfx1k_we, pgm_we}, 0);
    check("rst_dl_addr", dl_addr, 0);
    check("rst_dl_data", dl_data, 0);
    check("rst_busy", dl_busy, 0);
    check("rst_rom_ok", rom_ok, 0);
    check("rst_oob", oob_err, 0);
  endtask

  logic [3:0] mon_we;
  wr_t        mon_e;

  always @(negedge clk) begin
    mon_we = {prom_we, gfx1h_we, gfx1k_we, pgm_we};
    if (mon_we != 4'b0000) begin
      if (exp_q.size() == 0)
        check("unexpected_strobe", {4'd0, mon_we, dl_addr, dl_data}, 0);
      else begin
        mon_e = exp_q.pop_front();
        check("strobe", {4'd0, mon_we, dl_addr, dl_data}, {4'd0, mon_e.we, mon_e.addr, mon_e.data});
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit prev_ur;
    ioctl.ioctl_download = 1'b0;
    ioctl.ioctl_index    = 8'd0;
    ioctl.ioctl_wr       = 1'b0;
    ioctl.ioctl_addr     = 25'd0;
    ioctl.ioctl_dout     = 8'd0;

    repeat (3) @(negedge clk);
    check_reset_values();
    rst = 1'b0;

    // Partial download, then asynchronous reset while still in LOAD.
    @(negedge clk);
    ioctl.ioctl_download = 1'b1;
    model_cnt = 0;
    model_oob = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i > 0) @(negedge clk);
      drive_byte(25'($urandom_range(0, 'h601F)), 8'($urandom_range(1, 255)), 8'd0);
    end
    @(negedge clk);
    ioctl.ioctl_wr = 1'b0;
    @(negedge clk);
    check("busy_before_reset", dl_busy, 1);
    check("queue_before_reset", exp_q.size(), 0);
    #2 rst = 1'b1;
    #1 check_reset_values();
    ioctl.ioctl_download = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("norom_after_reset", core_reset, 1);

    // Good sequential image, first byte on the rising-edge cycle.
    send_image(IMG, 0, -1, 0);
    after_fall(1'b0);

    // user_reset reaches core_reset one cycle later while in RUN.
    prev_ur = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check("user_reset_path", core_reset, prev_ur);
      user_reset = (j >= 1 && j <= 3);
      prev_ur = user_reset;
    end

    // Foreign index, then writes with download low: both must be ignored.
    @(negedge clk);
    ioctl.ioctl_download = 1'b1;
    for (int j = 0; j < 20; j++) begin
      if (j > 0) @(negedge clk);
      drive_byte(25'($urandom_range(0, 'h601F)), 8'($urandom), 8'd1);
    end
    @(negedge clk);
    ioctl.ioctl_wr       = 1'b0;
    ioctl.ioctl_download = 1'b0;
    ioctl.ioctl_index    = 8'd0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      drive_byte(25'($urandom_range(0, 'h601F)), 8'($urandom), 8'd0);
    end
    @(negedge clk);
    ioctl.ioctl_wr = 1'b0;
    repeat (3) @(negedge clk);
    check("ignored_core_reset", core_reset, 0);
    check("ignored_busy", dl_busy, 0);
    check("ignored_rom_ok", rom_ok, 1);
    check("ignored_oob", oob_err, 0);
    check("ignored_queue", exp_q.size(), 0);

    // Random-address full image (rewrites count twice), cut short in HOLD
    // by a new download whose rise coincides with hold expiry.
    send_image(IMG, 1, -1, 0);
    after_fall(1'b1);

    // Stray byte at 0x6020 plus a full image.
    send_image(IMG, 0, 1, 0);
    after_fall(1'b0);

    // Truncated image with idle gaps.
    send_image(300, 1, -1, 25);
    after_fall(1'b0);

    // Addresses with bits set above bit 15.
    send_image(200, 2, -1, 10);
    after_fall(1'b0);

    repeat (3) @(negedge clk);
    check("final_queue", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
